barrel_shift_arbiter: RTL

//  Shares one combinational barrel shifter among N_REQ requesters via round-robin arbitration.

---
 rtl/barrel_shift_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/barrel_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shift_arbiter
//  Description : Round-robin arbiter that shares one external combinational
//                barrel shifter among N_REQ requesters. Shift amounts up to
//                2*(DATA_W-1) are served by running the shifter twice; the
//                tagged result is returned through a valid/ready port.
//  Ports       :
//    clk, rst              rising-edge clock, asynchronous active-high reset
//    req_valid/req_ready   per-requester handshake (one ready bit at most)
//    req_data/req_amt/     per-requester operand, amount and direction,
//    req_dir               packed as slices of width DATA_W / AMT_W / 1
//    sh_in_data/sh_shift/  operands driven to the shared shifter
//    sh_dir
//    sh_out_data           combinational result returned by the shifter
//    res_valid/res_ready   result handshake
//    res_data/res_id       shifted result and owning requester index
//  Revision    : 1.0  initial release
// ============================================================================
module barrel_shift_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  parameter int SH_W   = $clog2(DATA_W),
  parameter int AMT_W  = SH_W + 1,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*AMT_W-1:0]  req_amt,
  input  logic [N_REQ-1:0]        req_dir,
  output logic [DATA_W-1:0]       sh_in_data,
  output logic [SH_W-1:0]         sh_shift,
  output logic                    sh_dir,
  input  logic [DATA_W-1:0]       sh_out_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_W-1:0]       res_data,
  output logic [ID_W-1:0]         res_id
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_PASS1 = 2'd1;
  localparam logic [1:0] c_ST_PASS2 = 2'd2;
  localparam logic [1:0] c_ST_HOLD  = 2'd3;

  // Largest shift one pass of the shifter can apply, in both widths.
  localparam logic [AMT_W-1:0] c_PASS_MAX = AMT_W'(DATA_W - 1);
  localparam logic [SH_W-1:0]  c_SH_FULL  = SH_W'(DATA_W - 1);
  // Largest amount the two passes together can apply.
  localparam logic [AMT_W-1:0] c_AMT_MAX  = AMT_W'(2 * (DATA_W - 1));
  localparam logic [ID_W-1:0]  c_PTR_RST  = ID_W'(N_REQ - 1);

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [AMT_W-1:0]  r_amt;
  logic              r_dir;
  logic [DATA_W-1:0] r_acc;

  logic              w_grant_any;
  logic              w_grant_fire;
  logic [ID_W-1:0]   w_grant_id;
  logic [DATA_W-1:0] w_sel_data;
  logic [AMT_W-1:0]  w_sel_amt;
  logic              w_sel_dir;

  logic              w_two_pass;
  logic [AMT_W-1:0]  w_amt_clamped;
  logic [SH_W-1:0]   w_sh1;
  logic [SH_W-1:0]   w_sh2;

  // --------------------------------------------------------------------------
  // Round-robin selection
  // The search starts just after the last winner. It is done in two sweeps
  // over constant indices: first the requesters above r_ptr, then those at or
  // below it (wrap-around). The first valid hit wins and its payload is
  // multiplexed out for capture.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_sel_data  = '0;
    w_sel_amt   = '0;
    w_sel_dir   = 1'b0;
    for (int sweep = 0; sweep < 2; sweep++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_grant_any && req_valid[i] &&
            (((sweep == 0) && (ID_W'(i) >  r_ptr)) ||
             ((sweep == 1) && (ID_W'(i) <= r_ptr)))) begin
          w_grant_any = 1'b1;
          w_grant_id  = ID_W'(i);
          w_sel_data  = req_data[i*DATA_W +: DATA_W];
          w_sel_amt   = req_amt[i*AMT_W +: AMT_W];
          w_sel_dir   = req_dir[i];
        end
      end
    end
  end

  // A grant only exists in IDLE; reset forces it off so that req_ready is
  // low immediately while rst is held, even with requests pending.
  assign w_grant_fire = (r_state == c_ST_IDLE) && w_grant_any && !rst;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = w_grant_fire && (w_grant_id == ID_W'(gi));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pass amount split
  // Pass 1 applies up to DATA_W-1; pass 2 applies the remainder. Amounts
  // beyond the two-pass reach are clamped (the result is zero either way).
  // --------------------------------------------------------------------------
  assign w_two_pass    = (r_amt > c_PASS_MAX);
  assign w_amt_clamped = (r_amt > c_AMT_MAX) ? c_AMT_MAX : r_amt;
  assign w_sh1         = w_two_pass ? c_SH_FULL : r_amt[SH_W-1:0];
  assign w_sh2         = SH_W'(w_amt_clamped - c_PASS_MAX);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_grant_fire) w_state_nxt = c_ST_PASS1;
      c_ST_PASS1: w_state_nxt = w_two_pass ? c_ST_PASS2 : c_ST_HOLD;
      c_ST_PASS2: w_state_nxt = c_ST_HOLD;
      c_ST_HOLD:  if (res_ready) w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. The shifter inputs are zero unless a pass is running.
  // --------------------------------------------------------------------------
  always_comb begin
    sh_in_data = '0;
    sh_shift   = '0;
    sh_dir     = 1'b0;
    res_valid  = 1'b0;
    case (r_state)
      c_ST_PASS1: begin
        sh_in_data = r_data;
        sh_shift   = w_sh1;
        sh_dir     = r_dir;
      end
      c_ST_PASS2: begin
        sh_in_data = r_acc;
        sh_shift   = w_sh2;
        sh_dir     = r_dir;
      end
      c_ST_HOLD: begin
        res_valid  = 1'b1;
      end
      default: begin
        res_valid  = 1'b0;
      end
    endcase
  end

  // r_acc and r_id only change outside HOLD, so the result stays stable
  // while the consumer stalls.
  assign res_data = r_acc;
  assign res_id   = r_id;

  // --------------------------------------------------------------------------
  // Datapath registers: request capture, pointer and pass accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= c_PTR_RST;
      r_id   <= '0;
      r_data <= '0;
      r_amt  <= '0;
      r_dir  <= 1'b0;
      r_acc  <= '0;
    end else begin
      if (w_grant_fire) begin
        r_ptr  <= w_grant_id;
        r_id   <= w_grant_id;
        r_data <= w_sel_data;
        r_amt  <= w_sel_amt;
        r_dir  <= w_sel_dir;
      end
      if ((r_state == c_ST_PASS1) || (r_state == c_ST_PASS2)) begin
        r_acc <= sh_out_data;
      end
    end
  end

endmodule
`default_nettype wire
